// File: rtl/carfield_l2_port_sched_pkg.sv
// Shared types and the L2 address map for the two-port L2 scheduler.
// Request fields are sized for the default requester/data/offset configuration.
package carfield_l2_sched_pkg;

   // Address map of the two L2 ports
   localparam logic [63:0] L2Port0Base   = 64'h0000_0000_7800_0000;
   localparam logic [63:0] L2Port0Size   = 64'h0000_0000_0020_0000;
   localparam logic [63:0] L2Port1Base   = 64'h0000_0000_7820_0000;
   localparam logic [63:0] L2Port1Size   = 64'h0000_0000_0020_0000;
   localparam bit          L2Port0Enable = 1'b1;
   localparam bit          L2Port1Enable = 1'b1;

   localparam int SchedNumReq    = 4;
   localparam int SchedDataWidth = 64;
   localparam int SchedOffWidth  = 21;
   localparam int SchedIdxWidth  = (SchedNumReq > 1) ? $clog2(SchedNumReq) : 1;

   typedef enum logic [1:0] {
      PORT_IDLE,
      PORT_ISSUE,
      PORT_WAIT
   } port_state_e;

   typedef struct packed {
      logic [SchedIdxWidth-1:0]  idx;
      logic [SchedOffWidth-1:0]  offset;
      logic                      we;
      logic [SchedDataWidth-1:0] wdata;
   } port_req_t;

endpackage

// File: rtl/carfield_l2_port_fsm.sv
// One L2 port: round-robin arbiter over eligible requesters plus the
// IDLE/ISSUE/WAIT transaction FSM with registered L2-side fields.
module carfield_l2_port_fsm
   import carfield_l2_sched_pkg::*;
#(
   parameter int NumReq     = SchedNumReq,
   parameter int DataWidth  = SchedDataWidth,
   parameter int L2OffWidth = SchedOffWidth,
   parameter bit Enable     = 1'b1
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NumReq-1:0]                   cand_i,
   input  logic [NumReq-1:0][L2OffWidth-1:0]   off_i,
   input  logic [NumReq-1:0]                   we_i,
   input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
   output logic [NumReq-1:0]                   gnt_o,
   output logic [NumReq-1:0]                   rvalid_o,
   output logic [DataWidth-1:0]                rdata_o,
   output logic                                l2_req_o,
   output logic                                l2_we_o,
   output logic [L2OffWidth-1:0]               l2_addr_o,
   output logic [DataWidth-1:0]                l2_wdata_o,
   input  logic                                l2_gnt_i,
   input  logic                                l2_rvalid_i,
   input  logic [DataWidth-1:0]                l2_rdata_i
);

   localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

   port_state_e     state_q, state_d;
   logic [IdxW-1:0] ptr_q, ptr_d;
   port_req_t       cur_q, cur_d;
   logic            l2_req_q, l2_req_d;

   logic            win_vld;
   logic [IdxW-1:0] win_idx;
   logic            resp;

   // Scan downwards so the last hit is the lowest index at or above the pointer.
   always_comb begin
      int j;
      j       = 0;
      win_vld = 1'b0;
      win_idx = ptr_q;
      for (int k = NumReq - 1; k >= 0; k--) begin
         j = (int'(ptr_q) + k) % NumReq;
         if (cand_i[j]) begin
            win_vld = 1'b1;
            win_idx = IdxW'(j);
         end
      end
   end

   assign resp = (state_q == PORT_WAIT) && l2_rvalid_i;

   always_comb begin
      gnt_o    = '0;
      rvalid_o = '0;
      if (state_q == PORT_IDLE && win_vld) gnt_o[win_idx] = 1'b1;
      if (resp) rvalid_o[cur_q.idx] = 1'b1;
      rdata_o = (resp && !cur_q.we) ? l2_rdata_i : '0;
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cur_d    = cur_q;
      l2_req_d = l2_req_q;
      case (state_q)
         PORT_IDLE: begin
            if (win_vld) begin
               cur_d.idx    = SchedIdxWidth'(win_idx);
               cur_d.offset = off_i[win_idx];
               cur_d.we     = we_i[win_idx];
               cur_d.wdata  = wdata_i[win_idx];
               ptr_d        = (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + IdxW'(1);
               l2_req_d     = 1'b1;
               state_d      = PORT_ISSUE;
            end
         end
         PORT_ISSUE: begin
            if (l2_gnt_i) begin
               l2_req_d = 1'b0;
               state_d  = PORT_WAIT;
            end
         end
         PORT_WAIT: begin
            if (l2_rvalid_i) state_d = PORT_IDLE;
         end
         default: begin
            l2_req_d = 1'b0;
            state_d  = PORT_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= PORT_IDLE;
         ptr_q    <= '0;
         cur_q    <= '0;
         l2_req_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cur_q    <= cur_d;
         l2_req_q <= l2_req_d;
      end
   end

   assign l2_req_o   = l2_req_q & Enable;
   assign l2_we_o    = cur_q.we;
   assign l2_addr_o  = cur_q.offset;
   assign l2_wdata_o = cur_q.wdata;

endmodule

// File: rtl/carfield_l2_port_sched.sv
// Two-port L2 scheduler: address decode, per-requester outstanding tracking,
// decode-error responses and two independent port arbiters/FSMs.
module carfield_l2_port_sched
   import carfield_l2_sched_pkg::*;
#(
   parameter int NumReq     = 4,
   parameter int AddrWidth  = 48,
   parameter int DataWidth  = 64,
   parameter int L2OffWidth = 21
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [NumReq-1:0]                  req_i,
   input  logic [NumReq-1:0][AddrWidth-1:0]   addr_i,
   input  logic [NumReq-1:0]                  we_i,
   input  logic [NumReq-1:0][DataWidth-1:0]   wdata_i,
   output logic [NumReq-1:0]                  gnt_o,
   output logic [NumReq-1:0]                  rvalid_o,
   output logic [NumReq-1:0]                  err_o,
   output logic [NumReq-1:0][DataWidth-1:0]   rdata_o,
   output logic [1:0]                         l2_req_o,
   output logic [1:0]                         l2_we_o,
   output logic [1:0][L2OffWidth-1:0]         l2_addr_o,
   output logic [1:0][DataWidth-1:0]          l2_wdata_o,
   input  logic [1:0]                         l2_gnt_i,
   input  logic [1:0]                         l2_rvalid_i,
   input  logic [1:0][DataWidth-1:0]          l2_rdata_i
);

   localparam logic [1:0][AddrWidth-1:0] PortBase = {
      AddrWidth'(L2Port1Base), AddrWidth'(L2Port0Base)};
   localparam logic [1:0][AddrWidth-1:0] PortEnd = {
      AddrWidth'(L2Port1Base + L2Port1Size), AddrWidth'(L2Port0Base + L2Port0Size)};
   localparam logic [1:0] PortEnable = {L2Port1Enable, L2Port0Enable};

   logic [1:0][NumReq-1:0]                 hit;
   logic [1:0][NumReq-1:0][L2OffWidth-1:0] off;
   logic [1:0][NumReq-1:0]                 port_gnt;
   logic [1:0][NumReq-1:0]                 port_rv;
   logic [1:0][DataWidth-1:0]              port_rdata;

   logic [NumReq-1:0] outst_q, outst_d;
   logic [NumReq-1:0] errpend_q, errpend_d;
   logic [NumReq-1:0] err_gnt;
   logic [NumReq-1:0] gnt_raw;

   always_comb begin
      hit = '0;
      off = '0;
      for (int p = 0; p < 2; p++) begin
         for (int r = 0; r < NumReq; r++) begin
            hit[p][r] = PortEnable[p] && (addr_i[r] >= PortBase[p]) && (addr_i[r] < PortEnd[p]);
            off[p][r] = L2OffWidth'(addr_i[r] - PortBase[p]);
         end
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      carfield_l2_port_fsm #(
         .NumReq     (NumReq),
         .DataWidth  (DataWidth),
         .L2OffWidth (L2OffWidth),
         .Enable     (PortEnable[gi])
      ) u_port_fsm (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .cand_i      (req_i & hit[gi] & ~outst_q),
         .off_i       (off[gi]),
         .we_i        (we_i),
         .wdata_i     (wdata_i),
         .gnt_o       (port_gnt[gi]),
         .rvalid_o    (port_rv[gi]),
         .rdata_o     (port_rdata[gi]),
         .l2_req_o    (l2_req_o[gi]),
         .l2_we_o     (l2_we_o[gi]),
         .l2_addr_o   (l2_addr_o[gi]),
         .l2_wdata_o  (l2_wdata_o[gi]),
         .l2_gnt_i    (l2_gnt_i[gi]),
         .l2_rvalid_i (l2_rvalid_i[gi]),
         .l2_rdata_i  (l2_rdata_i[gi])
      );
   end

   // Unmapped addresses need no shared resource, so every such requester is granted at once.
   assign err_gnt = req_i & ~hit[0] & ~hit[1] & ~outst_q;
   assign gnt_raw = port_gnt[0] | port_gnt[1] | err_gnt;
   assign gnt_o   = gnt_raw & ~{NumReq{rst_i}};

   assign rvalid_o = port_rv[0] | port_rv[1] | errpend_q;
   assign err_o    = errpend_q;

   always_comb begin
      rdata_o = '0;
      for (int r = 0; r < NumReq; r++) begin
         if (port_rv[0][r])      rdata_o[r] = port_rdata[0];
         else if (port_rv[1][r]) rdata_o[r] = port_rdata[1];
      end
   end

   always_comb begin
      outst_d   = (outst_q | gnt_raw) & ~rvalid_o;
      errpend_d = err_gnt;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         outst_q   <= '0;
         errpend_q <= '0;
      end else begin
         outst_q   <= outst_d;
         errpend_q <= errpend_d;
      end
   end

endmodule

// File: tb/tb_carfield_l2_port_sched.sv
// Directed scenarios followed by random traffic, every cycle checked
// against a transaction-level model of the scheduler.
module tb_carfield_l2_port_sched;

   localparam int N  = 4;
   localparam int AW = 48;
   localparam int DW = 64;
   localparam int OW = 21;

   logic                 clk;
   logic                 rst;
   logic [N-1:0]         req;
   logic [N-1:0][AW-1:0] addr;
   logic [N-1:0]         we;
   logic [N-1:0][DW-1:0] wdata;
   logic [N-1:0]         gnt_o;
   logic [N-1:0]         rvalid_o;
   logic [N-1:0]         err_o;
   logic [N-1:0][DW-1:0] rdata_o;
   logic [1:0]           l2_req_o;
   logic [1:0]           l2_we_o;
   logic [1:0][OW-1:0]   l2_addr_o;
   logic [1:0][DW-1:0]   l2_wdata_o;
   logic [1:0]           l2_gnt;
   logic [1:0]           l2_rvalid;
   logic [1:0][DW-1:0]   l2_rdata;

   carfield_l2_port_sched dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_i       (req),
      .addr_i      (addr),
      .we_i        (we),
      .wdata_i     (wdata),
      .gnt_o       (gnt_o),
      .rvalid_o    (rvalid_o),
      .err_o       (err_o),
      .rdata_o     (rdata_o),
      .l2_req_o    (l2_req_o),
      .l2_we_o     (l2_we_o),
      .l2_addr_o   (l2_addr_o),
      .l2_wdata_o  (l2_wdata_o),
      .l2_gnt_i    (l2_gnt),
      .l2_rvalid_i (l2_rvalid),
      .l2_rdata_i  (l2_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Transaction-level reference model.
   // Port phase: 0 = free, 1 = waiting for L2 acceptance, 2 = waiting for L2 response.
   int              m_ptr   [2];
   int              m_phase [2];
   int              m_idx   [2];
   logic [OW-1:0]   m_off   [2];
   logic            m_we    [2];
   logic [DW-1:0]   m_wd    [2];
   bit              m_busy  [N];
   bit              m_errdue[N];

   logic [N-1:0]    e_gnt, e_rv, e_err, e_errg;
   int              e_win   [2];

   function automatic int decode(input logic [AW-1:0] a);
      if (a >= 48'h0000_7800_0000 && a < 48'h0000_7820_0000) return 0;
      if (a >= 48'h0000_7820_0000 && a < 48'h0000_7840_0000) return 1;
      return -1;
   endfunction

   function automatic logic [AW-1:0] port_base(input int p);
      return (p == 0) ? 48'h0000_7800_0000 : 48'h0000_7820_0000;
   endfunction

   task automatic model_reset();
      for (int p = 0; p < 2; p++) begin
         m_ptr[p] = 0; m_phase[p] = 0; m_idx[p] = 0;
      end
      for (int r = 0; r < N; r++) begin
         m_busy[r] = 0; m_errdue[r] = 0;
      end
   endtask

   task automatic model_check();
      int r;
      logic [1:0] exp_l2req;
      e_gnt = '0; e_rv = '0; e_err = '0; e_errg = '0;
      for (int i = 0; i < N; i++)
         if (req[i] && !m_busy[i] && decode(addr[i]) < 0) e_errg[i] = 1'b1;
      e_gnt = e_errg;
      for (int p = 0; p < 2; p++) begin
         e_win[p] = -1;
         if (m_phase[p] == 0) begin
            for (int k = 0; k < N; k++) begin
               r = (m_ptr[p] + k) % N;
               if (e_win[p] < 0 && req[r] && !m_busy[r] && decode(addr[r]) == p) e_win[p] = r;
            end
            if (e_win[p] >= 0) e_gnt[e_win[p]] = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (m_errdue[i]) begin
            e_rv[i] = 1'b1; e_err[i] = 1'b1;
            chk("err_rdata", rdata_o[i], 64'h0);
         end
      end
      for (int p = 0; p < 2; p++) begin
         if (m_phase[p] == 2 && l2_rvalid[p]) begin
            e_rv[m_idx[p]] = 1'b1;
            chk("resp_rdata", rdata_o[m_idx[p]], m_we[p] ? 64'h0 : l2_rdata[p]);
         end
      end
      exp_l2req = {m_phase[1] == 1, m_phase[0] == 1};
      chk("gnt", gnt_o, e_gnt);
      chk("rvalid", rvalid_o, e_rv);
      chk("err", err_o, e_err);
      chk("l2_req", l2_req_o, exp_l2req);
      for (int p = 0; p < 2; p++) begin
         if (m_phase[p] == 1) begin
            chk("l2_addr", l2_addr_o[p], m_off[p]);
            chk("l2_we", l2_we_o[p], m_we[p]);
            chk("l2_wdata", l2_wdata_o[p], m_wd[p]);
         end
      end
   endtask

   task automatic model_update();
      logic [AW-1:0] d;
      for (int i = 0; i < N; i++) begin
         if (e_rv[i]) m_busy[i] = 0;
         if (e_gnt[i]) m_busy[i] = 1;
         m_errdue[i] = e_errg[i];
      end
      for (int p = 0; p < 2; p++) begin
         if (m_phase[p] == 0 && e_win[p] >= 0) begin
            m_phase[p] = 1;
            m_idx[p]   = e_win[p];
            d          = addr[e_win[p]] - port_base(p);
            m_off[p]   = d[OW-1:0];
            m_we[p]    = we[e_win[p]];
            m_wd[p]    = wdata[e_win[p]];
            m_ptr[p]   = (e_win[p] + 1) % N;
         end else if (m_phase[p] == 1 && l2_gnt[p]) begin
            m_phase[p] = 2;
         end else if (m_phase[p] == 2 && l2_rvalid[p]) begin
            m_phase[p] = 0;
         end
      end
   endtask

   // Inputs change 1 time unit after a rising edge; checks happen mid-cycle.
   task automatic settle();
      #2;
   endtask

   task automatic tick();
      #3;
      model_check();
      @(posedge clk);
      model_update();
      #1;
   endtask

   function automatic logic [AW-1:0] pick_addr();
      logic [AW-1:0] a;
      case ($urandom_range(0, 7))
         0: a = 48'h0000_7800_0000 + AW'($urandom_range(0, 32'h1F_FFFF));
         1: a = 48'h0000_7820_0000 + AW'($urandom_range(0, 32'h1F_FFFF));
         2: a = 48'h0000_7800_0000;
         3: a = 48'h0000_781F_FFFF;
         4: a = 48'h0000_7820_0000;
         5: a = 48'h0000_783F_FFFF;
         6: a = 48'h0000_7840_0000;
         default: a = 48'h0000_77FF_FFFF;
      endcase
      return a;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [N-1:0] exp_g;
      model_reset();
      rst       = 1'b1;
      req       = '1;
      we        = '0;
      wdata     = '0;
      l2_gnt    = '0;
      l2_rvalid = '0;
      l2_rdata  = '0;
      for (int r = 0; r < N; r++) addr[r] = 48'h0000_7800_0000;

      // Reset state: all outputs zero even with requests pending
      settle();
      chk("rst_gnt", gnt_o, 0);
      chk("rst_rvalid", rvalid_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_l2req", l2_req_o, 0);
      chk("rst_l2addr", l2_addr_o[0], 0);
      chk("rst_l2wdata", l2_wdata_o[1], 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Round-robin order with a 5-cycle L2 stall on the first transaction
      for (int r = 0; r < N; r++) begin
         req[r]   = 1'b1;
         addr[r]  = 48'h0000_7800_0040 + AW'(r * 32'h100);
         we[r]    = 1'b1;
         wdata[r] = 64'hA0 + 64'(r);
      end
      for (int k = 0; k < 5; k++) begin
         exp_g = 4'b0001 << (k % 4);
         settle();
         chk("rr_order", gnt_o, exp_g);
         tick();
         if (k == 0) begin
            repeat (5) begin
               settle();
               chk("hold_addr", l2_addr_o[0], 21'h40);
               chk("hold_wdata", l2_wdata_o[0], 64'hA0);
               tick();
            end
         end
         l2_gnt = 2'b01; tick(); l2_gnt = 2'b00;
         l2_rvalid = 2'b01; l2_rdata[0] = {$urandom, $urandom}; tick(); l2_rvalid = 2'b00;
      end
      req = '0; we = '0;

      // Read on port 0
      req = 4'b0001; addr[0] = 48'h0000_7800_0010;
      settle(); chk("rd0_gnt", gnt_o, 4'b0001); tick();
      req = '0; l2_gnt = 2'b01;
      settle(); chk("rd0_l2req", l2_req_o, 2'b01); chk("rd0_l2addr", l2_addr_o[0], 21'h10); tick();
      l2_gnt = '0; l2_rvalid = 2'b01; l2_rdata[0] = 64'hCAFE;
      settle(); chk("rd0_rvalid", rvalid_o, 4'b0001); chk("rd0_rdata", rdata_o[0], 64'hCAFE); tick();
      l2_rvalid = '0;

      // Write on port 1
      req = 4'b0010; addr[1] = 48'h0000_7820_0004; we[1] = 1'b1; wdata[1] = 64'h1234_5678;
      settle(); chk("wr1_gnt", gnt_o, 4'b0010); tick();
      req = '0; l2_gnt = 2'b10;
      settle();
      chk("wr1_l2req", l2_req_o, 2'b10);
      chk("wr1_l2addr", l2_addr_o[1], 21'h4);
      chk("wr1_l2we", l2_we_o[1], 1);
      chk("wr1_l2wdata", l2_wdata_o[1], 64'h1234_5678);
      tick();
      l2_gnt = '0; l2_rvalid = 2'b10; l2_rdata[1] = 64'hDEAD;
      settle(); chk("wr1_rvalid", rvalid_o, 4'b0010); chk("wr1_rdata", rdata_o[1], 0); tick();
      l2_rvalid = '0; we = '0;

      // Decode error
      req = 4'b0100; addr[2] = 48'h0000_6000_0000;
      settle(); chk("derr_gnt", gnt_o, 4'b0100); chk("derr_l2req", l2_req_o, 0); tick();
      req = '0;
      settle();
      chk("derr_rvalid", rvalid_o, 4'b0100);
      chk("derr_err", err_o, 4'b0100);
      chk("derr_rdata", rdata_o[2], 0);
      chk("derr_l2req2", l2_req_o, 0);
      tick();

      // Both ports concurrently
      req = 4'b0011; addr[0] = 48'h0000_7800_0100; addr[1] = 48'h0000_7820_0200;
      settle(); chk("dual_gnt", gnt_o, 4'b0011); tick();
      req = '0; l2_gnt = 2'b11;
      settle(); chk("dual_l2req", l2_req_o, 2'b11); tick();
      l2_gnt = '0; l2_rvalid = 2'b01; l2_rdata[0] = 64'hAA; l2_rdata[1] = 64'hBB;
      settle(); chk("dual_rv0", rvalid_o, 4'b0001); chk("dual_rd0", rdata_o[0], 64'hAA); tick();
      l2_rvalid = 2'b10;
      settle(); chk("dual_rv1", rvalid_o, 4'b0010); chk("dual_rd1", rdata_o[1], 64'hBB); tick();
      l2_rvalid = '0;

      // Reset while a transaction waits for its response
      req = 4'b1000; addr[3] = 48'h0000_7800_0020;
      tick();
      req = '0; l2_gnt = 2'b01; tick(); l2_gnt = '0;
      rst = 1'b1; l2_rvalid = 2'b01; req = 4'b0001; addr[0] = 48'h0000_7820_0000;
      settle();
      chk("wrst_rvalid", rvalid_o, 0);
      chk("wrst_gnt", gnt_o, 0);
      chk("wrst_err", err_o, 0);
      chk("wrst_l2req", l2_req_o, 0);
      chk("wrst_l2addr", l2_addr_o[0], 0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0; l2_rvalid = '0;
      settle(); chk("post_rst_gnt", gnt_o, 4'b0001); tick();
      req = '0; l2_gnt = 2'b10; tick(); l2_gnt = '0;
      l2_rvalid = 2'b10; tick(); l2_rvalid = '0;

      // Random traffic
      repeat (400) begin
         for (int r = 0; r < N; r++) begin
            req[r]   = ($urandom_range(0, 9) < 6);
            addr[r]  = pick_addr();
            we[r]    = 1'($urandom_range(0, 1));
            wdata[r] = {$urandom, $urandom};
         end
         l2_gnt    = 2'($urandom_range(0, 3));
         l2_rvalid = 2'($urandom_range(0, 3));
         l2_rdata[0] = {$urandom, $urandom};
         l2_rdata[1] = {$urandom, $urandom};
         tick();
      end

      // Drain
      req = '0; l2_gnt = 2'b11; l2_rvalid = 2'b11;
      repeat (6) tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
